// File: rtl/gpu_instruction_dispatcher.sv
// Pops GPU instructions, latches the command fields and issues them to the fill/line/arc raster units.
// Optional WAIT watchdog with abort: define GPU_DISPATCH_WATCHDOG_EN.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_instruction_dispatcher #(
   parameter logic [3:0] OP_NOP  = 4'h0,
   parameter logic [3:0] OP_FILL = 4'h1,
   parameter logic [3:0] OP_LINE = 4'h2,
   parameter logic [3:0] OP_ARC  = 4'h3
`ifdef GPU_DISPATCH_WATCHDOG_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       enable_i,
   input  logic                       fifo_empty_i,
   output logic                       fifo_pop_o,
   input  logic [3:0]                 fifo_opcode_i,
   input  logic [`WIDTH_BITS-1:0]     fifo_x1_i,
   input  logic [`HEIGHT_BITS-1:0]    fifo_y1_i,
   input  logic [`WIDTH_BITS-1:0]     fifo_x2_i,
   input  logic [`HEIGHT_BITS-1:0]    fifo_y2_i,
   input  logic [`WIDTH_BITS-1:0]     fifo_rad_i,
   input  logic [`CHANNEL_BITS-1:0]   fifo_r_i,
   input  logic [`CHANNEL_BITS-1:0]   fifo_g_i,
   input  logic [`CHANNEL_BITS-1:0]   fifo_b_i,
   input  logic [2:0]                 fifo_oct_i,
   output logic [3:0]                 cmd_opcode_o,
   output logic [`WIDTH_BITS-1:0]     cmd_x1_o,
   output logic [`HEIGHT_BITS-1:0]    cmd_y1_o,
   output logic [`WIDTH_BITS-1:0]     cmd_x2_o,
   output logic [`HEIGHT_BITS-1:0]    cmd_y2_o,
   output logic [`WIDTH_BITS-1:0]     cmd_rad_o,
   output logic [`CHANNEL_BITS-1:0]   cmd_r_o,
   output logic [`CHANNEL_BITS-1:0]   cmd_g_o,
   output logic [`CHANNEL_BITS-1:0]   cmd_b_o,
   output logic [2:0]                 cmd_oct_o,
   output logic [2:0]                 start_o,
   input  logic [2:0]                 done_i,
   output logic [2:0]                 abort_o,
   output logic                       busy_o,
   output logic                       bad_opcode_o,
   output logic                       timeout_o,
   input  logic                       clear_err_i
);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;

   state_t     state_q, state_d;
   logic [2:0] active_q, active_d;
   logic       bad_q, bad_set;
   logic       done_hit;

`ifdef GPU_DISPATCH_WATCHDOG_EN
   localparam logic [9:0] TIMEOUT_VAL = 10'(TIMEOUT_CYCLES);
   logic [9:0] cnt_q;
   logic [2:0] abort_q;
   logic       timeout_q;
   logic       wd_fire;
`endif

   assign done_hit = |(done_i & active_q);

   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      bad_set  = 1'b0;
`ifdef GPU_DISPATCH_WATCHDOG_EN
      wd_fire  = 1'b0;
`endif
      case (state_q)
         IDLE: if (enable_i && !fifo_empty_i) state_d = FETCH;
         FETCH: begin
            state_d = IDLE;
            if (fifo_opcode_i == OP_FILL) begin
               active_d = 3'b001;
               state_d  = ISSUE;
            end else if (fifo_opcode_i == OP_LINE) begin
               active_d = 3'b010;
               state_d  = ISSUE;
            end else if (fifo_opcode_i == OP_ARC) begin
               active_d = 3'b100;
               state_d  = ISSUE;
            end else if (fifo_opcode_i != OP_NOP) begin
               bad_set = 1'b1;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (done_hit) begin
               state_d = IDLE;
`ifdef GPU_DISPATCH_WATCHDOG_EN
            // fires on the cycle the count reaches the limit; a same-cycle done wins above
            end else if (cnt_q + 10'd1 == TIMEOUT_VAL) begin
               state_d = IDLE;
               wd_fire = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         active_q     <= '0;
         bad_q        <= 1'b0;
         cmd_opcode_o <= '0;
         cmd_x1_o     <= '0;
         cmd_y1_o     <= '0;
         cmd_x2_o     <= '0;
         cmd_y2_o     <= '0;
         cmd_rad_o    <= '0;
         cmd_r_o      <= '0;
         cmd_g_o      <= '0;
         cmd_b_o      <= '0;
         cmd_oct_o    <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         if (clear_err_i)  bad_q <= 1'b0;
         else if (bad_set) bad_q <= 1'b1;
         if (state_q == FETCH) begin
            cmd_opcode_o <= fifo_opcode_i;
            cmd_x1_o     <= fifo_x1_i;
            cmd_y1_o     <= fifo_y1_i;
            cmd_x2_o     <= fifo_x2_i;
            cmd_y2_o     <= fifo_y2_i;
            cmd_rad_o    <= fifo_rad_i;
            cmd_r_o      <= fifo_r_i;
            cmd_g_o      <= fifo_g_i;
            cmd_b_o      <= fifo_b_i;
            cmd_oct_o    <= fifo_oct_i;
         end
      end
   end

`ifdef GPU_DISPATCH_WATCHDOG_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q     <= '0;
         abort_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == ISSUE)     cnt_q <= '0;
         else if (state_q == WAIT) cnt_q <= cnt_q + 10'd1;
         abort_q <= wd_fire ? active_q : 3'b000;
         if (clear_err_i)  timeout_q <= 1'b0;
         else if (wd_fire) timeout_q <= 1'b1;
      end
   end

   assign abort_o   = abort_q;
   assign timeout_o = timeout_q;
`else
   assign abort_o   = '0;
   assign timeout_o = 1'b0;
`endif

   assign fifo_pop_o   = (state_q == FETCH);
   assign start_o      = (state_q == ISSUE) ? active_q : 3'b000;
   assign busy_o       = (state_q != IDLE);
   assign bad_opcode_o = bad_q;

endmodule

// File: tb/tb_gpu_instruction_dispatcher.sv
// Bench for gpu_instruction_dispatcher: emulated FIFO and raster units, checked against a
// cycle-timeline model of the dispatch rules. Watchdog cases active with GPU_DISPATCH_WATCHDOG_EN.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module tb_gpu_instruction_dispatcher;
   localparam int unsigned WB = `WIDTH_BITS;
   localparam int unsigned HB = `HEIGHT_BITS;
   localparam int unsigned CB = `CHANNEL_BITS;
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_FILL = 4'h1;
   localparam logic [3:0] OP_LINE = 4'h2;
   localparam logic [3:0] OP_ARC  = 4'h3;
   localparam int WD_LIMIT = 16;
   localparam int NEVER    = -1;

   typedef struct packed {
      logic [3:0]    op;
      logic [WB-1:0] x1;
      logic [HB-1:0] y1;
      logic [WB-1:0] x2;
      logic [HB-1:0] y2;
      logic [WB-1:0] rad;
      logic [CB-1:0] r;
      logic [CB-1:0] g;
      logic [CB-1:0] b;
      logic [2:0]    oct;
   } instr_t;
   localparam int unsigned CMD_W = $bits(instr_t);
   typedef logic [CMD_W-1:0] val_t;

   logic clk = 1'b0;
   logic n_rst, enable_i, fifo_empty_i, fifo_pop_o, clear_err_i;
   logic busy_o, bad_opcode_o, timeout_o;
   logic [2:0] start_o, done_i, abort_o;
   instr_t head, cmd_obs;
   logic [3:0]    cmd_opcode_o;
   logic [WB-1:0] cmd_x1_o, cmd_x2_o, cmd_rad_o;
   logic [HB-1:0] cmd_y1_o, cmd_y2_o;
   logic [CB-1:0] cmd_r_o, cmd_g_o, cmd_b_o;
   logic [2:0]    cmd_oct_o;

   always #5 clk = ~clk;

   assign cmd_obs = {cmd_opcode_o, cmd_x1_o, cmd_y1_o, cmd_x2_o, cmd_y2_o,
                     cmd_rad_o, cmd_r_o, cmd_g_o, cmd_b_o, cmd_oct_o};

   gpu_instruction_dispatcher #(
      .OP_NOP(OP_NOP),
      .OP_FILL(OP_FILL),
      .OP_LINE(OP_LINE),
      .OP_ARC(OP_ARC)
`ifdef GPU_DISPATCH_WATCHDOG_EN
      , .TIMEOUT_CYCLES(WD_LIMIT)
`endif
   ) dut (
      .clk(clk), .n_rst(n_rst), .enable_i(enable_i),
      .fifo_empty_i(fifo_empty_i), .fifo_pop_o(fifo_pop_o),
      .fifo_opcode_i(head.op), .fifo_x1_i(head.x1), .fifo_y1_i(head.y1),
      .fifo_x2_i(head.x2), .fifo_y2_i(head.y2), .fifo_rad_i(head.rad),
      .fifo_r_i(head.r), .fifo_g_i(head.g), .fifo_b_i(head.b), .fifo_oct_i(head.oct),
      .cmd_opcode_o(cmd_opcode_o), .cmd_x1_o(cmd_x1_o), .cmd_y1_o(cmd_y1_o),
      .cmd_x2_o(cmd_x2_o), .cmd_y2_o(cmd_y2_o), .cmd_rad_o(cmd_rad_o),
      .cmd_r_o(cmd_r_o), .cmd_g_o(cmd_g_o), .cmd_b_o(cmd_b_o), .cmd_oct_o(cmd_oct_o),
      .start_o(start_o), .done_i(done_i), .abort_o(abort_o), .busy_o(busy_o),
      .bad_opcode_o(bad_opcode_o), .timeout_o(timeout_o), .clear_err_i(clear_err_i)
   );

   // Timeline model: each accepted instruction fixes the cycles of its pop, start and completion.
   instr_t q[$];
   instr_t last_cmd;
   int cyc, free_from, pop_cyc, start_cyc, done_cyc, abort_cyc, bad_cyc;
   logic [2:0] unit;
   bit pend_pop, clr_prev, exp_bad, exp_to;
   int en_pct, fill_pct, clr_pct, force_d, pops, starts;
   int unsigned n_tests, n_fail;

   task automatic check(input string tag, input val_t got, input val_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [2:0] unit_of(input logic [3:0] op);
      if (op == OP_FILL) return 3'b001;
      if (op == OP_LINE) return 3'b010;
      if (op == OP_ARC)  return 3'b100;
      return 3'b000;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      int unsigned r;
      r     = $urandom_range(15);
      i.x1  = WB'($urandom);
      i.y1  = HB'($urandom);
      i.x2  = WB'($urandom);
      i.y2  = HB'($urandom);
      i.rad = WB'($urandom);
      i.r   = CB'($urandom);
      i.g   = CB'($urandom);
      i.b   = CB'($urandom);
      i.oct = 3'($urandom);
      if (r < 4)       i.op = OP_FILL;
      else if (r < 8)  i.op = OP_LINE;
      else if (r < 12) i.op = OP_ARC;
      else if (r < 14) i.op = OP_NOP;
      else             i.op = 4'($urandom_range(15, 4));
      return i;
   endfunction

   function automatic instr_t mk(input logic [3:0] op);
      instr_t i;
      i    = rand_instr();
      i.op = op;
      return i;
   endfunction

   function automatic int pick_delay();
      int unsigned r;
      r = $urandom_range(9);
      if (force_d > 0) return force_d;
      if (r < 6) return int'($urandom_range(4, 1));
      if (r < 9) return int'(r) + 9;
      return int'($urandom_range(25, 18));
   endfunction

   task automatic schedule();
      int d;
      logic [2:0] u;
      pop_cyc = cyc + 1;
      u = unit_of(q[0].op);
      if (u != 3'b000) begin
         unit      = u;
         start_cyc = cyc + 2;
         d         = pick_delay();
`ifdef GPU_DISPATCH_WATCHDOG_EN
         if (d > WD_LIMIT) begin
            abort_cyc = start_cyc + WD_LIMIT + 1;
            free_from = abort_cyc;
            done_cyc  = NEVER;
         end else
`endif
         begin
            done_cyc  = start_cyc + d;
            free_from = done_cyc + 1;
         end
      end else begin
         free_from = cyc + 2;
         if (q[0].op != OP_NOP) bad_cyc = cyc + 2;
      end
   endtask

   task automatic step();
      bit en;
      @(posedge clk);
      #1;
      cyc++;
      if (pend_pop) begin
         last_cmd = q.pop_front();
         pend_pop = 1'b0;
      end
      if (clr_prev) begin
         exp_bad = 1'b0;
         exp_to  = 1'b0;
      end else begin
         if (cyc == bad_cyc)   exp_bad = 1'b1;
         if (cyc == abort_cyc) exp_to  = 1'b1;
      end
      check("busy", val_t'(busy_o), val_t'(cyc < free_from));
      check("pop", val_t'(fifo_pop_o), val_t'(cyc == pop_cyc));
      check("start", val_t'(start_o), val_t'((cyc == start_cyc) ? unit : 3'b000));
      check("abort", val_t'(abort_o), val_t'((cyc == abort_cyc) ? unit : 3'b000));
      check("cmd", cmd_obs, last_cmd);
      check("bad_opcode", val_t'(bad_opcode_o), val_t'(exp_bad));
      check("timeout", val_t'(timeout_o), val_t'(exp_to));
      if (fifo_pop_o) pops++;
      if (start_o != 3'b000) starts++;
      if (cyc == pop_cyc) pend_pop = 1'b1;

      en = ($urandom_range(99) < en_pct);
      if ($urandom_range(99) < fill_pct && q.size() < 6) q.push_back(rand_instr());
      if (cyc >= free_from && en && q.size() > 0) schedule();
      enable_i     = en;
      fifo_empty_i = (q.size() == 0);
      head         = (q.size() > 0) ? q[0] : rand_instr();
      clear_err_i  = ($urandom_range(99) < clr_pct);
      clr_prev     = clear_err_i;
      if (cyc == done_cyc)       done_i = unit | (3'($urandom) & ~unit);
      else if (cyc == start_cyc) done_i = 3'($urandom);
      else                       done_i = 3'($urandom) & ~unit;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic apply_reset();
      n_rst        = 1'b0;
      enable_i     = 1'b0;
      clear_err_i  = 1'b0;
      done_i       = 3'b000;
      fifo_empty_i = 1'b1;
      head         = '0;
      free_from    = 0;
      pop_cyc      = NEVER;
      start_cyc    = NEVER;
      done_cyc     = NEVER;
      abort_cyc    = NEVER;
      bad_cyc      = NEVER;
      unit         = 3'b000;
      last_cmd     = '0;
      pend_pop     = 1'b0;
      clr_prev     = 1'b0;
      exp_bad      = 1'b0;
      exp_to       = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   initial begin
      instr_t t;
      n_tests = 0; n_fail = 0; cyc = 0;
      en_pct = 0; fill_pct = 0; clr_pct = 0; force_d = 0;
      apply_reset();
      run(2);

      // LINE x1=5 y1=7 r=FF, done three cycles after start
      t = mk(OP_LINE); t.x1 = WB'(5); t.y1 = HB'(7); t.r = '1;
      q.push_back(t); en_pct = 100; force_d = 3;
      run(10);

      // FILL, NOP, ARC: three pops, two starts
      pops = 0; starts = 0;
      q.push_back(mk(OP_FILL)); q.push_back(mk(OP_NOP)); q.push_back(mk(OP_ARC));
      run(25);
      check("fna_pops", val_t'(pops), val_t'(3));
      check("fna_starts", val_t'(starts), val_t'(2));

      // unknown opcode: one pop, no start, sticky flag until cleared
      pops = 0; starts = 0;
      q.push_back(mk(4'hA));
      run(8);
      check("bad_pops", val_t'(pops), val_t'(1));
      check("bad_starts", val_t'(starts), val_t'(0));
      check("bad_sticky", val_t'(bad_opcode_o), val_t'(1));
      clr_pct = 100; run(1); clr_pct = 0; run(2);
      check("bad_cleared", val_t'(bad_opcode_o), val_t'(0));

      // enable low with a non-empty FIFO
      pops = 0; en_pct = 0;
      q.push_back(mk(OP_FILL));
      run(20);
      check("disabled_pops", val_t'(pops), val_t'(0));

      // enable dropped while the unit is busy
      pops = 0; en_pct = 100; force_d = 8;
      q.push_back(mk(OP_ARC));
      run(4);
      en_pct = 0;
      run(16);
      check("drop_en_pops", val_t'(pops), val_t'(1));
      check("drop_en_left", val_t'(q.size()), val_t'(1));
      en_pct = 100; force_d = 2;
      run(8);

      // done on the limit cycle vs one cycle late
      q.push_back(mk(OP_LINE)); force_d = WD_LIMIT + 1; run(25);
      q.push_back(mk(OP_LINE)); force_d = WD_LIMIT;     run(25);

      // reset in WAIT clears every output immediately
      q.push_back(mk(OP_LINE)); force_d = 30;
      run(5);
      check("wait_busy", val_t'(busy_o), val_t'(1));
      #2 n_rst = 1'b0;
      #1;
      check("rst_flags", val_t'({busy_o, fifo_pop_o, start_o, abort_o, bad_opcode_o, timeout_o}), val_t'(0));
      check("rst_cmd", cmd_obs, val_t'(0));
      apply_reset();
      run(3);

      // random traffic
      force_d = 0; en_pct = 85; fill_pct = 40; clr_pct = 3;
      run(1500);
      en_pct = 0; fill_pct = 0; clr_pct = 0;
      run(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
